// File: rtl/cgra_pkg.sv
// Shared types for the CGRA context sequencer: FSM state encoding and the
// packed context-table entry {last, next_pc, rpt}.
package cgra_pkg;

    localparam int CGRA_PC_WIDTH  = 4;
    localparam int CGRA_RPT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } seq_state_t;

    // Field order matches the packed cfg write word {last, next_pc, repeat}.
    typedef struct packed {
        logic                      last;
        logic [CGRA_PC_WIDTH-1:0]  next_pc;
        logic [CGRA_RPT_WIDTH-1:0] rpt;
    } context_entry_t;

    // An unprogrammed slot issues once and ends the program.
    function automatic context_entry_t reset_entry();
        return '{last: 1'b1, next_pc: '0, rpt: '0};
    endfunction

endpackage

// File: rtl/cgra_context_sequencer.sv
// Context sequencer for a CGRA: walks a flop-based context table, issuing each
// slot repeat+1 times, with stall, abort, issue budget and config-error reporting.
module cgra_context_sequencer
    import cgra_pkg::*;
#(
    parameter int CONTEXT_DEPTH = 16,
    // Widths must agree with the package entry layout.
    parameter int PC_WIDTH      = CGRA_PC_WIDTH,
    parameter int RPT_WIDTH     = CGRA_RPT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_we_i,
    input  logic [PC_WIDTH-1:0]           cfg_addr_i,
    input  logic [RPT_WIDTH+PC_WIDTH:0]   cfg_wdata_i,
    output logic                          cfg_err_o,
    input  logic                          start_i,
    input  logic                          abort_i,
    input  logic [PC_WIDTH-1:0]           entry_pc_i,
    input  logic [31:0]                   max_steps_i,
    input  logic                          stall_i,
    output logic [PC_WIDTH-1:0]           context_pc_o,
    output logic                          context_valid_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          timeout_o,
    output logic [31:0]                   step_count_o
);

    seq_state_t           state_q, state_d;
    context_entry_t       ctx_table [CONTEXT_DEPTH];
    context_entry_t       entry;
    logic [PC_WIDTH-1:0]  pc_q;
    logic [RPT_WIDTH-1:0] rpt_cnt_q;
    logic [31:0]          step_count_q;
    logic                 issue, final_issue, program_end, budget_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: all clocked state uses non-blocking assignment so every flop
            // samples pre-edge values regardless of block ordering.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        state_d         = state_q;
        entry           = ctx_table[pc_q];
        issue           = (state_q == RUN) && !stall_i;
        final_issue     = issue && (rpt_cnt_q == entry.rpt);
        program_end     = final_issue && entry.last;
        budget_hit      = issue && (max_steps_i != 32'd0) && (step_count_q + 32'd1 == max_steps_i);
        context_valid_o = issue;
        busy_o          = (state_q == RUN);
        done_o          = (state_q == FINISH);

        case (state_q)
            IDLE:    if (start_i && !abort_i) state_d = RUN;
            RUN: begin
                if (abort_i)                        state_d = IDLE;
                else if (program_end || budget_hit) state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the table is deliberately flops so each entry can be reset;
            // a RAM-mapped memory could not take this per-entry reset value.
            for (int i = 0; i < CONTEXT_DEPTH; i++) ctx_table[i] <= reset_entry();
            pc_q         <= '0;
            rpt_cnt_q    <= '0;
            step_count_q <= '0;
            timeout_o    <= 1'b0;
            cfg_err_o    <= 1'b0;
        end else begin
            cfg_err_o <= cfg_we_i && (state_q != IDLE);
            if (state_q == IDLE) begin
                // Write and start share the edge, so a same-cycle start sees the new entry.
                if (cfg_we_i) ctx_table[cfg_addr_i] <= context_entry_t'(cfg_wdata_i);
                if (start_i && !abort_i) begin
                    pc_q         <= entry_pc_i;
                    rpt_cnt_q    <= '0;
                    step_count_q <= '0;
                    timeout_o    <= 1'b0;
                end
            end else if (issue) begin
                step_count_q <= step_count_q + 32'd1;
                if (!abort_i) begin
                    if (!final_issue) begin
                        rpt_cnt_q <= rpt_cnt_q + RPT_WIDTH'(1);
                    end else if (!entry.last) begin
                        pc_q      <= entry.next_pc;
                        rpt_cnt_q <= '0;
                    end
                    if (budget_hit && !program_end) timeout_o <= 1'b1;
                end
            end
        end
    end

    assign context_pc_o = pc_q;
    assign step_count_o = step_count_q;

endmodule

// File: tb/tb_cgra_context_sequencer.sv
// Self-checking bench: a per-cycle behavioural model of the sequencer is compared
// with the DUT on every falling edge; directed programs pin the model with literals.
module tb_cgra_context_sequencer;

    localparam int BOUND = 400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we_i = 1'b0;
    logic [3:0]  cfg_addr_i = '0;
    logic [12:0] cfg_wdata_i = '0;
    logic        cfg_err_o;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [3:0]  entry_pc_i = '0;
    logic [31:0] max_steps_i = '0;
    logic        stall_i = 1'b0;
    logic [3:0]  context_pc_o;
    logic        context_valid_o;
    logic        busy_o;
    logic        done_o;
    logic        timeout_o;
    logic [31:0] step_count_o;

    cgra_context_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i),
        .cfg_err_o(cfg_err_o),
        .start_i(start_i), .abort_i(abort_i), .entry_pc_i(entry_pc_i),
        .max_steps_i(max_steps_i), .stall_i(stall_i),
        .context_pc_o(context_pc_o), .context_valid_o(context_valid_o),
        .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
        .step_count_o(step_count_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_state;        // 0 idle, 1 running, 2 finishing
    int          m_pc, m_iss;    // current slot, issues of it so far
    logic [31:0] m_steps;
    bit          m_timeout, m_err;
    int          t_rpt [16];
    int          t_next[16];
    bit          t_last[16];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_pc = 0; m_iss = 0; m_steps = 0; m_timeout = 0; m_err = 0;
            for (int i = 0; i < 16; i++) begin t_rpt[i] = 0; t_next[i] = 0; t_last[i] = 1; end
        end else begin
            m_err = cfg_we_i && (m_state != 0);
            case (m_state)
                0: begin
                    if (cfg_we_i) begin
                        t_rpt[cfg_addr_i]  = int'(cfg_wdata_i[7:0]);
                        t_next[cfg_addr_i] = int'(cfg_wdata_i[11:8]);
                        t_last[cfg_addr_i] = cfg_wdata_i[12];
                    end
                    if (start_i && !abort_i) begin
                        m_state = 1; m_pc = int'(entry_pc_i); m_iss = 0; m_steps = 0; m_timeout = 0;
                    end
                end
                1: begin
                    if (!stall_i) m_steps = m_steps + 1;
                    if (abort_i) m_state = 0;
                    else if (!stall_i) begin
                        bit slot_done, prog_end, budget;
                        m_iss++;
                        slot_done = (m_iss == t_rpt[m_pc] + 1);
                        prog_end  = slot_done && t_last[m_pc];
                        budget    = (max_steps_i != 0) && (m_steps == max_steps_i);
                        if (slot_done && !t_last[m_pc]) begin m_pc = t_next[m_pc]; m_iss = 0; end
                        if (prog_end) m_state = 2;
                        else if (budget) begin m_state = 2; m_timeout = 1; end
                    end
                end
                default: m_state = 0;
            endcase
        end
    end

    // ---------------- compare process + event log ----------------
    int cyc = 0, last_valid_cyc = 0, done_cyc = 0;
    int done_cnt = 0, err_cnt = 0, stall_cnt = 0;
    int issued[$];

    always @(negedge clk) begin
        cyc++;
        check("busy",    32'(busy_o),          32'(m_state == 1));
        check("valid",   32'(context_valid_o), 32'(m_state == 1 && !stall_i));
        check("done",    32'(done_o),          32'(m_state == 2));
        check("timeout", 32'(timeout_o),       32'(m_timeout));
        check("cfg_err", 32'(cfg_err_o),       32'(m_err));
        check("pc",      32'(context_pc_o),    32'(m_pc));
        check("steps",   step_count_o,         m_steps);
        if (context_valid_o) begin issued.push_back(int'(context_pc_o)); last_valid_cyc = cyc; end
        if (done_o) begin done_cnt++; done_cyc = cyc; end
        if (cfg_err_o) err_cnt++;
        if (busy_o && !context_valid_o) stall_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_slot(input int a, input int rpt, input int nxt, input bit last);
        cfg_we_i = 1'b1; cfg_addr_i = 4'(a); cfg_wdata_i = {last, 4'(nxt), 8'(rpt)};
        tick();
        cfg_we_i = 1'b0;
    endtask

    task automatic clear_log();
        issued.delete(); done_cnt = 0; err_cnt = 0; stall_cnt = 0;
    endtask

    task automatic run(input int entry, input int max, input int stall_at, input int stall_len,
                       input int abort_at, input int we_at, input bit rnd);
        int k = 0;
        entry_pc_i = 4'(entry); max_steps_i = 32'(max); start_i = 1'b1;
        tick();
        start_i = 1'b0;
        while (busy_o && k < BOUND) begin
            stall_i  = rnd ? ($urandom_range(0, 4) == 0) : (k >= stall_at && k < stall_at + stall_len);
            abort_i  = (k == abort_at);
            cfg_we_i = (k == we_at);
            if (k == we_at) begin cfg_addr_i = 4'd5; cfg_wdata_i = {1'b1, 4'd0, 8'd0}; end
            tick();
            k++;
        end
        stall_i = 1'b0; abort_i = 1'b0; cfg_we_i = 1'b0;
        check("run_bound", 32'(k < BOUND), 32'd1);
        tick();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Three-slot program: 0 -> 1 (x2) -> 2 (x3, last).
        write_slot(0, 0, 1, 0); write_slot(1, 1, 2, 0); write_slot(2, 2, 0, 1);
        clear_log();
        run(0, 0, -1, 0, -1, -1, 0);
        check("seq_len", 32'(issued.size()), 32'd6);
        if (issued.size() == 6) check("seq", {issued[0][3:0], issued[1][3:0], issued[2][3:0],
                                             issued[3][3:0], issued[4][3:0], issued[5][3:0], 8'h0},
                                      32'h0112_2200);
        check("seq_steps", step_count_o, 32'd6);
        check("seq_done_cnt", 32'(done_cnt), 32'd1);
        check("seq_done_lat", 32'(done_cyc - last_valid_cyc), 32'd1);
        tick();
        check("steps_hold", step_count_o, 32'd6);

        // Same program with a 3-cycle stall inside slot 1.
        clear_log();
        run(0, 0, 2, 3, -1, -1, 0);
        check("stall_len", 32'(issued.size()), 32'd6);
        if (issued.size() == 6) check("stall_seq", {issued[0][3:0], issued[1][3:0], issued[2][3:0],
                                               issued[3][3:0], issued[4][3:0], issued[5][3:0], 8'h0},
                                      32'h0112_2200);
        check("stall_gaps", 32'(stall_cnt), 32'd3);
        check("stall_steps", step_count_o, 32'd6);

        // Self-loop on slot 5 with a budget of 10.
        write_slot(5, 0, 5, 0);
        clear_log();
        run(5, 10, -1, 0, -1, -1, 0);
        check("loop_issues", 32'(issued.size()), 32'd10);
        check("loop_done", 32'(done_cnt), 32'd1);
        check("loop_timeout", 32'(timeout_o), 32'd1);

        // Budget hit on the final issue of a last slot: natural end wins.
        write_slot(3, 3, 0, 1);
        clear_log();
        run(3, 4, -1, 0, -1, -1, 0);
        check("tie_issues", 32'(issued.size()), 32'd4);
        check("tie_done", 32'(done_cnt), 32'd1);
        check("tie_timeout", 32'(timeout_o), 32'd0);

        // Write during RUN is rejected; abort ends the run with no done.
        clear_log();
        run(5, 0, -1, 0, 6, 2, 0);
        check("run_write_err", 32'(err_cnt), 32'd1);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_issues", 32'(issued.size()), 32'd7);
        clear_log();
        run(5, 3, -1, 0, -1, -1, 0);
        check("table_kept", 32'(timeout_o), 32'd1);

        // Abort held in IDLE blocks start.
        abort_i = 1'b1; start_i = 1'b1; tick();
        abort_i = 1'b0; start_i = 1'b0;
        check("abort_blocks", 32'(busy_o), 32'd0);

        // Write and start in the same cycle.
        cfg_we_i = 1'b1; cfg_addr_i = 4'd9; cfg_wdata_i = {1'b1, 4'd0, 8'd2};
        clear_log();
        run(9, 0, -1, 0, -1, -1, 0);
        check("same_cycle_wr", 32'(issued.size()), 32'd3);

        // Reset clears the table: slot 7 issues once.
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        clear_log();
        run(7, 0, -1, 0, -1, -1, 0);
        check("reset_slot7", 32'(issued.size()), 32'd1);
        check("reset_done", 32'(done_cnt), 32'd1);

        // Randomized programs, stalls, aborts and stray writes.
        for (int r = 0; r < 40; r++) begin
            for (int s = 0; s < 16; s++)
                write_slot(s, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 2) == 0);
            run($urandom_range(0, 15), $urandom_range(1, 60), -1, 0,
                ($urandom_range(0, 4) == 0) ? $urandom_range(0, 20) : -1,
                ($urandom_range(0, 2) == 0) ? $urandom_range(0, 10) : -1, 1);
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
